ahb_rd_ctrl: RTL
================

// Module: ahb_rd_ctrl
// PURPOSE
//  AHB-Lite slave transfer controller for the 4-entry read-only register bank (status/payload0/payload1/size).
//  Decodes the address phase and sequences the registered read mux (read_select/rd_en).
//  Generates HREADYOUT/HRESP, including wait states and the two-cycle ERROR response.
//  Owns the sticky error-status flags the bank returns at register 0.
// PARAMETERS
//  ADDR_W       8  HADDR width; register index = haddr[3:2], haddr[ADDR_W-1:4] must be 0
//  WAIT_STATES  0  extra wait cycles (0..15) inserted before the intrinsic read cycle
// PORTS
//  hclk         in   1       clock
//  hreset_n     in   1       reset, asynchronous, active-low
//  hsel         in   1       slave select
//  haddr        in   ADDR_W  address-phase address
//  htrans       in   2       0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//  hwrite       in   1       address-phase direction
//  hsize        in   3       address-phase size
//  hready       in   1       bus HREADY (previous transfer complete)
//  reg_busy     in   1       bank not ready; stalls the wait counter and rd_en
//  read_select  out  2       register index to the read mux
//  rd_en        out  1       one-cycle strobe; mux registers hrdata on this edge
//  err_status   out  2       sticky flags {write_err, addr_err} to the mux register 0
//  hready_out   out  1       HREADYOUT
//  hresp        out  1       HRESP, 0 OKAY, 1 ERROR
// BEHAVIOUR
//  Reset: state IDLE, read_select=0, rd_en=0, err_status=0, hready_out=1, hresp=0.
//   Reset is asynchronous and aborts any transfer at any point.
//  Accept: in the cycle with hsel && hready && htrans[1], the address phase is captured.
//   IDLE/BUSY or !hsel -> stay IDLE, with hready_out=1 and hresp=0.
//  Error decode for an accepted transfer:
//   hwrite=1 -> ERROR, sets write_err.
//   haddr[ADDR_W-1:4]!=0, haddr[1:0]!=0 or hsize>2 -> ERROR, sets addr_err.
//   Both write_err and addr_err may set in the same transfer.
//  States: IDLE, WAIT, READ, DONE, ERR1, ERR2.
//   Valid read: read_select <= haddr[3:2] at the accept edge; held until the next accept.
//     Goes to WAIT if WAIT_STATES>0, else READ.
//   WAIT: hready_out=0, hresp=0; counter loads WAIT_STATES, decrements when !reg_busy; goes to READ at 1->0.
//   READ: hready_out=0, hresp=0; rd_en=1 when !reg_busy (stays in READ while busy); then DONE.
//   DONE: hready_out=1, hresp=0.
//   ERR1: hready_out=0, hresp=1.  ERR2: hready_out=1, hresp=1.  No rd_en is issued in either.
//  Pipelining: DONE/ERR2 are completion cycles; a new accept in them goes straight to WAIT/READ/ERR1.
//   Without a new accept, they go to IDLE.
//  Latency: OKAY read completes 2+WAIT_STATES cycles after the accept edge (plus reg_busy stall cycles).
//  err_status: sticky; cleared at the rd_en edge when read_select==0.
//   Any flag set by an error accepted in the same cycle wins over that clear.
//  ERR1/ERR2 never stall on reg_busy.
// TESTING
//  WAIT_STATES=0, NONSEQ read 0x04 -> read_select=1; rd_en in cycle 1; hready_out pattern 0,1; hresp=0.
//  WAIT_STATES=2, read 0x0C with reg_busy high for 1 cycle -> hready_out low for 4 cycles; single rd_en; read_select=3.
//  Write 0x08 -> ERR1 (hresp=1, hready_out=0) then ERR2 (1,1); err_status=2'b10; no rd_en.
//  Read 0x10 then read 0x00 -> ERROR then OKAY; err_status=01 at rd_en of the second read, 00 afterwards.
//  Back-to-back SEQ reads 0x04, 0x08 -> second accepted in DONE; no IDLE cycle; read_select 1 then 2.
//  hreset_n low during WAIT -> immediately hready_out=1, hresp=0, rd_en=0, err_status=0, state IDLE.

Source files
------------

// File: rtl/ahb_rd_ctrl.sv
// AHB-Lite slave transfer controller for a 4-entry read-only register bank.
// Sequences the read mux, wait states, two-cycle ERROR and sticky error flags.
module ahb_rd_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              hready,
  input  logic              reg_busy,
  output logic [1:0]        read_select,
  output logic              rd_en,
  output logic [1:0]        err_status,
  output logic              hready_out,
  output logic              hresp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t     state;
  logic [3:0] wcnt;
  logic       open;
  logic       accept;
  logic       addr_bad;
  logic [1:0] err_set;
  logic       rd_clr;
  logic       unused_bits;

  // A new address phase is only taken while our data phase is not stalling.
  assign open = (state == S_IDLE) ||
                (state == S_DONE) ||
                (state == S_ERR2);

  assign accept = open && hsel && hready && htrans[1];

  assign addr_bad = (haddr[ADDR_W-1:4] != '0) ||
                    (haddr[1:0] != 2'b00) ||
                    (hsize > 3'd2);

  assign err_set = accept ? {hwrite, addr_bad} : 2'b00;

  // The strobe must follow reg_busy in the same cycle, so it is decoded
  // from the state register rather than registered a cycle early.
  assign rd_en  = (state == S_READ) && !reg_busy;
  assign rd_clr = rd_en && (read_select == 2'd0);

  assign unused_bits = htrans[0];

  // Transfer FSM with registered bus responses and read index.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      read_select <= '0;
      hready_out  <= 1'b1;
      hresp       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR2: begin
          if (accept && (err_set != 2'b00)) begin
            state      <= S_ERR1;
            hready_out <= 1'b0;
            hresp      <= 1'b1;
          end else if (accept) begin
            read_select <= haddr[3:2];
            wcnt        <= WS;
            hready_out  <= 1'b0;
            hresp       <= 1'b0;
            if (WS != 4'd0) state <= S_WAIT;
            else            state <= S_READ;
          end else begin
            state      <= S_IDLE;
            hready_out <= 1'b1;
            hresp      <= 1'b0;
          end
        end
        S_WAIT: begin
          if (!reg_busy) begin
            wcnt <= wcnt - 4'd1;
            if (wcnt == 4'd1) state <= S_READ;
          end
        end
        S_READ: begin
          if (!reg_busy) begin
            state      <= S_DONE;
            hready_out <= 1'b1;
          end
        end
        S_ERR1: begin
          state      <= S_ERR2;
          hready_out <= 1'b1;
          hresp      <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          hready_out <= 1'b1;
          hresp      <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags; a fresh error outranks the clear from reading register 0.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      err_status <= 2'b00;
    end else begin
      err_status <= (rd_clr ? 2'b00 : err_status) | err_set;
    end
  end

endmodule
